// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one op per handshake, single-outstanding valid/ready memory bus,
// byte-lane alignment, load extension and misaligned/bus-error/timeout reporting.
module ysyx_23060332_lsu #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_ren,
   input  logic        in_wen,
   input  logic [2:0]  in_func3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   input  logic        mem_resp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_reg_wen,
   output logic        out_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_in_ready;
   logic        r_wen;
   logic [2:0]  r_func3;
   logic [1:0]  r_sh;
   logic [CNT_W-1:0] r_cnt;
   logic        r_req_valid;
   logic        r_req_wen;
   logic [31:0] r_req_addr;
   logic [31:0] r_req_wdata;
   logic [3:0]  r_req_wmask;
   logic        r_out_valid;
   logic [31:0] r_out_rdata;
   logic [4:0]  r_out_rd;
   logic        r_out_reg_wen;
   logic        r_out_err;

   // Stores have no unsigned forms, so func3 100/101 is only legal for loads.
   function automatic logic f_bad(input logic i_store, input logic [2:0] i_f3, input logic [1:0] i_a);
      logic v_bad;
      case (i_f3)
         3'b000:         v_bad = 1'b0;
         3'b001, 3'b101: v_bad = i_a[0] | i_store;
         3'b010:         v_bad = (i_a != 2'b00);
         3'b100:         v_bad = i_store;
         default:        v_bad = 1'b1;
      endcase
      if (i_f3 == 3'b001) v_bad = i_a[0];
      else                v_bad = v_bad;
      return v_bad;
   endfunction

   function automatic logic [3:0] f_wmask(input logic [2:0] i_f3, input logic [1:0] i_sh);
      logic [3:0] v_m;
      case (i_f3[1:0])
         2'b00:   v_m = 4'b0001;
         2'b01:   v_m = 4'b0011;
         2'b10:   v_m = 4'b1111;
         default: v_m = 4'b0000;
      endcase
      return v_m << i_sh;
   endfunction

   function automatic logic [31:0] f_load(input logic [31:0] i_d, input logic [2:0] i_f3, input logic [1:0] i_sh);
      logic [31:0] v_w;
      logic [31:0] v_r;
      v_w = i_d >> {i_sh, 3'b000};
      case (i_f3)
         3'b000:  v_r = {{24{v_w[7]}}, v_w[7:0]};
         3'b001:  v_r = {{16{v_w[15]}}, v_w[15:0]};
         3'b010:  v_r = v_w;
         3'b100:  v_r = {24'h000000, v_w[7:0]};
         3'b101:  v_r = {16'h0000, v_w[15:0]};
         default: v_r = 32'h0000_0000;
      endcase
      return v_r;
   endfunction

   // Main FSM: all bus and writeback outputs are registers updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_in_ready    <= 1'b1;
         r_wen         <= 1'b0;
         r_func3       <= 3'b000;
         r_sh          <= 2'b00;
         r_cnt         <= {CNT_W{1'b0}};
         r_req_valid   <= 1'b0;
         r_req_wen     <= 1'b0;
         r_req_addr    <= 32'h0000_0000;
         r_req_wdata   <= 32'h0000_0000;
         r_req_wmask   <= 4'b0000;
         r_out_valid   <= 1'b0;
         r_out_rdata   <= 32'h0000_0000;
         r_out_rd      <= 5'd0;
         r_out_reg_wen <= 1'b0;
         r_out_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in_ready    <= 1'b0;
                  r_wen         <= in_wen;
                  r_func3       <= in_func3;
                  r_sh          <= in_addr[1:0];
                  r_out_rd      <= in_rd;
                  r_out_rdata   <= 32'h0000_0000;
                  r_out_reg_wen <= 1'b0;
                  if (!in_ren && !in_wen) begin
                     r_out_err   <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (f_bad(in_wen, in_func3, in_addr[1:0])) begin
                     r_out_err   <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_req_valid <= 1'b1;
                     r_req_wen   <= in_wen;
                     r_req_addr  <= {in_addr[31:2], 2'b00};
                     r_req_wdata <= in_wen ? (in_wdata << {in_addr[1:0], 3'b000}) : 32'h0000_0000;
                     r_req_wmask <= in_wen ? f_wmask(in_func3, in_addr[1:0]) : 4'b0000;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_cnt       <= {CNT_W{1'b0}};
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A response in the final timeout cycle takes priority over the abort.
               if (mem_resp_valid) begin
                  r_out_valid   <= 1'b1;
                  r_out_err     <= mem_resp_err;
                  r_out_reg_wen <= ~r_wen & ~mem_resp_err;
                  r_out_rdata   <= (~r_wen & ~mem_resp_err) ? f_load(mem_resp_rdata, r_func3, r_sh) : 32'h0000_0000;
                  r_state       <= S_DONE;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_out_valid <= 1'b1;
                  r_out_err   <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign mem_req_valid = r_req_valid;
   assign mem_req_wen   = r_req_wen;
   assign mem_req_addr  = r_req_addr;
   assign mem_req_wdata = r_req_wdata;
   assign mem_req_wmask = r_req_wmask;
   assign out_valid     = r_out_valid;
   assign out_rdata     = r_out_rdata;
   assign out_rd        = r_out_rd;
   assign out_reg_wen   = r_out_reg_wen;
   assign out_err       = r_out_err;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed self-checking bench for ysyx_23060332_lsu with hand-computed expectations.
module tb_ysyx_23060332_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_ren, in_wen;
   logic [2:0]  in_func3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid, mem_resp_err;
   logic [31:0] mem_resp_rdata;
   logic        out_valid, out_ready, out_reg_wen, out_err;
   logic [31:0] out_rdata;
   logic [4:0]  out_rd;

   int n_tests = 0;
   int n_fail  = 0;
   int k;

   ysyx_23060332_lsu #(.TIMEOUT(255), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
      .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
      .out_reg_wen(out_reg_wen), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      in_valid = 1'b1; in_ren = ren; in_wen = wen; in_func3 = f3;
      in_addr = addr; in_wdata = wd; in_rd = rd;
      step();
      in_valid = 1'b0;
   endtask

   // From REQ with ready=1: handshake edge, then one WAIT cycle carrying the response.
   task automatic respond(input logic [31:0] d, input logic e);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = d; mem_resp_err = e;
      step();
      mem_resp_valid = 1'b0;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_func3 = 3'b000;
      in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
      out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_out_rdata", out_rdata, 32'h0);

      // SW aligned
      accept(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd1);
      chk("sw_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("sw_req_wen", {31'd0, mem_req_wen}, 32'd1);
      chk("sw_addr", mem_req_addr, 32'h8000_0004);
      chk("sw_wmask", {28'd0, mem_req_wmask}, 32'hF);
      chk("sw_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      respond(32'h0, 1'b0);
      chk("sw_out_valid", {31'd0, out_valid}, 32'd1);
      chk("sw_err", {31'd0, out_err}, 32'd0);
      chk("sw_reg_wen", {31'd0, out_reg_wen}, 32'd0);
      chk("sw_done_in_ready", {31'd0, in_ready}, 32'd0);
      retire();
      chk("sw_back_idle", {31'd0, in_ready}, 32'd1);

      // SB top lane
      accept(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd2);
      chk("sb_addr", mem_req_addr, 32'h8000_0000);
      chk("sb_wmask", {28'd0, mem_req_wmask}, 32'h8);
      chk("sb_wdata", mem_req_wdata, 32'hA500_0000);
      respond(32'h0, 1'b0);
      retire();

      // LB sign-extended from lane 1
      accept(1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 5'd5);
      chk("lb_req_wen", {31'd0, mem_req_wen}, 32'd0);
      chk("lb_wmask", {28'd0, mem_req_wmask}, 32'h0);
      respond(32'h0000_8000, 1'b0);
      chk("lb_rdata", out_rdata, 32'hFFFF_FF80);
      chk("lb_reg_wen", {31'd0, out_reg_wen}, 32'd1);
      chk("lb_rd", {27'd0, out_rd}, 32'd5);
      retire();

      // LHU upper half
      accept(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd6);
      respond(32'hBEEF_0000, 1'b0);
      chk("lhu_rdata", out_rdata, 32'h0000_BEEF);
      retire();

      // LH upper half, negative
      accept(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd7);
      respond(32'h8001_0000, 1'b0);
      chk("lh_rdata", out_rdata, 32'hFFFF_8001);
      retire();

      // LW misaligned: done one cycle after accept, no bus request
      accept(1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0, 5'd8);
      chk("lwmis_out_valid", {31'd0, out_valid}, 32'd1);
      chk("lwmis_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("lwmis_err", {31'd0, out_err}, 32'd1);
      chk("lwmis_reg_wen", {31'd0, out_reg_wen}, 32'd0);
      retire();

      // Undefined func3
      accept(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd9);
      chk("undef_err", {31'd0, out_err}, 32'd1);
      chk("undef_req_valid", {31'd0, mem_req_valid}, 32'd0);
      retire();

      // No-op
      accept(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 5'd3);
      chk("nop_out_valid", {31'd0, out_valid}, 32'd1);
      chk("nop_err", {31'd0, out_err}, 32'd0);
      chk("nop_reg_wen", {31'd0, out_reg_wen}, 32'd0);
      retire();

      // Bus error on load
      accept(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd4);
      respond(32'h1234_5678, 1'b1);
      chk("buserr_err", {31'd0, out_err}, 32'd1);
      chk("buserr_rdata", out_rdata, 32'h0);
      chk("buserr_reg_wen", {31'd0, out_reg_wen}, 32'd0);
      retire();

      // SH with request back-pressure, then response timeout
      mem_req_ready = 1'b0;
      accept(1'b0, 1'b1, 3'b001, 32'h8000_0012, 32'h0000_1234, 5'd0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
         chk("stall_addr", mem_req_addr, 32'h8000_0010);
         chk("stall_wmask", {28'd0, mem_req_wmask}, 32'hC);
         chk("stall_wdata", mem_req_wdata, 32'h1234_0000);
         step();
      end
      mem_req_ready = 1'b1;
      step();
      chk("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
      k = 0;
      while (!out_valid && k < 400) begin
         step();
         k++;
      end
      chk("timeout_cycles", k, 32'd255);
      chk("timeout_err", {31'd0, out_err}, 32'd1);
      chk("timeout_rdata", out_rdata, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_err", {31'd0, out_err}, 32'd1);
      end
      retire();

      // Response in the final timeout cycle wins
      accept(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd10);
      step();
      for (int i = 0; i < 254; i++) step();
      chk("late_still_wait", {31'd0, out_valid}, 32'd0);
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D; mem_resp_err = 1'b0;
      step();
      mem_resp_valid = 1'b0;
      chk("edge_resp_valid", {31'd0, out_valid}, 32'd1);
      chk("edge_resp_err", {31'd0, out_err}, 32'd0);
      chk("edge_resp_rdata", out_rdata, 32'hCAFE_F00D);
      retire();

      // Reset while waiting; late response ignored
      accept(1'b1, 1'b0, 3'b010, 32'h8000_0024, 32'h0, 5'd11);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstwait_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rstwait_out_valid", {31'd0, out_valid}, 32'd0);
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
      step();
      mem_resp_valid = 1'b0;
      step();
      chk("lateresp_out_valid", {31'd0, out_valid}, 32'd0);
      chk("lateresp_in_ready", {31'd0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
